// File: rtl/div_arbiter_if.sv
// Request, response and divider-side signal bundle for div_arbiter.
// slave = arbiter side, master = requesters plus the shared divider.
interface div_arbiter_if #(
    parameter int D_W   = 32,
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*D_W-1:0] req_dividend;
    logic [N_REQ*D_W-1:0] req_divisor;

    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic [D_W-1:0]       resp_quotient;
    logic                 resp_err;

    logic                 div_in_valid;
    logic                 div_enable;
    logic [D_W-1:0]       div_dividend;
    logic [D_W-1:0]       div_divisor;
    logic                 div_rst;
    logic [D_W-1:0]       div_quotient;
    logic                 div_out_valid;

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        input  div_quotient, div_out_valid,
        output req_ready,
        output resp_valid, resp_id, resp_quotient, resp_err,
        output div_in_valid, div_enable,
        output div_dividend, div_divisor, div_rst
    );

    modport master (
        output req_valid, req_dividend, req_divisor,
        output div_quotient, div_out_valid,
        input  req_ready,
        input  resp_valid, resp_id, resp_quotient, resp_err,
        input  div_in_valid, div_enable,
        input  div_dividend, div_divisor, div_rst
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin sharing of one iterative divider among N_REQ requesters.
// Optional DIV_ARB_TIMEOUT_EN: abort a stuck divide after TIMEOUT WAIT cycles.
module div_arbiter #(
    parameter int D_W     = 32,
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic            busy,
    div_arbiter_if.slave    bus
);

    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("div_arbiter: N_REQ must be 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] gnt_nxt;
    logic            gnt_any;
    logic            can_grant;
    logic [D_W-1:0]  gnt_a;
    logic [D_W-1:0]  gnt_b;
    logic            timeout_hit;

    logic            resp_pend_q;
    logic [ID_W-1:0] resp_id_q;
    logic [D_W-1:0]  resp_q_q;
    logic            resp_err_q;
    logic [D_W-1:0]  dvd_q;
    logic [D_W-1:0]  dvs_q;

    // First valid requester at or after the pointer, cyclically.
    always_comb begin
        logic [ID_W:0] idx;
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ))
                idx = idx - (ID_W+1)'(N_REQ);
            if (!gnt_any && bus.req_valid[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx[ID_W-1:0];
            end
        end
    end

    assign gnt_nxt = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    assign gnt_a   = bus.req_dividend[int'(gnt_id)*D_W +: D_W];
    assign gnt_b   = bus.req_divisor[int'(gnt_id)*D_W +: D_W];

    // The cycle that emits a response never grants.
    assign can_grant = (state_q == IDLE) && !resp_pend_q
                     && !stall && !rst && gnt_any;

    always_comb begin
        bus.req_ready = '0;
        if (can_grant)
            bus.req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (can_grant)
                    state_d = (gnt_b == '0) ? RESP : ISSUE;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.div_out_valid || timeout_hit)
                    state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
        if (stall)
            state_d = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            resp_pend_q <= 1'b0;
            resp_id_q   <= '0;
            resp_q_q    <= '0;
            resp_err_q  <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
        end else if (!stall) begin
            state_q     <= state_d;
            resp_pend_q <= (state_q == RESP);
            if (can_grant) begin
                rr_q      <= gnt_nxt;
                resp_id_q <= gnt_id;
                dvd_q     <= gnt_a;
                dvs_q     <= gnt_b;
                if (gnt_b == '0) begin
                    resp_q_q   <= '1;
                    resp_err_q <= 1'b1;
                end else begin
                    resp_err_q <= 1'b0;
                end
            end
            if (state_q == WAIT && bus.div_out_valid) begin
                resp_q_q   <= bus.div_quotient;
                resp_err_q <= 1'b0;
            end else if (state_q == WAIT && timeout_hit) begin
                resp_q_q   <= '1;
                resp_err_q <= 1'b1;
            end
        end
    end

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             div_rst_q;

    // A real out_valid wins over a coincident expiry.
    assign timeout_hit = (state_q == WAIT) && !stall
                       && !bus.div_out_valid
                       && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            div_rst_q  <= 1'b0;
        end else begin
            div_rst_q <= timeout_hit;
            if (!stall) begin
                if (state_q == ISSUE)
                    wait_cnt_q <= '0;
                else if (state_q == WAIT)
                    wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign bus.div_rst = div_rst_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.div_rst = 1'b0;
`endif

    assign bus.resp_valid    = resp_pend_q && !stall;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_quotient = resp_q_q;
    assign bus.resp_err      = resp_err_q;

    assign bus.div_in_valid  = (state_q == ISSUE);
    assign bus.div_enable    = !stall;
    assign bus.div_dividend  = dvd_q;
    assign bus.div_divisor   = dvs_q;

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a queue-based result model
// and a behavioural fixed-latency divider.
module tb_div_arbiter;
    localparam int D_W   = 32;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int TMO   = 8;
    localparam int LAT   = 6;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic stall = 1'b0;
    logic busy;

    div_arbiter_if #(.D_W(D_W), .N_REQ(N_REQ), .ID_W(ID_W)) bif();

    div_arbiter #(
        .D_W(D_W), .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .busy(busy), .bus(bif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Divider: answers LAT enabled cycles after in_valid, freezes when disabled.
    logic           hang   = 1'b0;
    logic           dbusy  = 1'b0;
    int             dcnt   = 0;
    int             ov_cyc = -100;
    logic [D_W-1:0] da, db;

    initial begin
        bif.div_out_valid = 1'b0;
        bif.div_quotient  = '0;
    end

    always @(negedge clk) begin
        if (rst || bif.div_rst) begin
            dbusy = 1'b0;
            bif.div_out_valid = 1'b0;
        end else if (bif.div_enable) begin
            bif.div_out_valid = 1'b0;
            if (bif.div_in_valid && !dbusy) begin
                dbusy = 1'b1;
                dcnt  = LAT;
                da    = bif.div_dividend;
                db    = bif.div_divisor;
            end else if (dbusy && !hang) begin
                dcnt--;
                if (dcnt == 0) begin
                    dbusy = 1'b0;
                    bif.div_out_valid = 1'b1;
                    bif.div_quotient  = (db == 0) ? '1 : da / db;
                    ov_cyc = cyc;
                end
            end
        end
    end

    typedef struct {
        int             id;
        logic [D_W-1:0] q;
        logic           err;
        int             gcyc;
        bit             dz;
    } exp_t;

    exp_t           expq[$];
    int             gnt_log[$];
    int             ptr       = 0;
    int             resp_cnt  = 0;
    int             issues    = 0;
    int             nz_grants = 0;
    int             drst_cnt  = 0;
    int             last_gcyc = 0;
    int             last_id   = -1;
    logic [D_W-1:0] last_q    = '0;
    logic           last_err  = 1'b0;
    bit             stalled   = 1'b0;
    logic [D_W-1:0] cur_a, cur_b;

    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
            ptr = 0;
            chk("ready_in_rst", bif.req_ready, '0);
        end else begin
            chk("enable", bif.div_enable, !stall);
            chk("ready_onehot", $countones(bif.req_ready) <= 1, 1'b1);
            if (stall) begin
                stalled = 1'b1;
                chk("stall_ready", bif.req_ready, '0);
                chk("stall_resp", bif.resp_valid, 1'b0);
            end
            if (busy && expq.size() > 0) begin
                chk("hold_dividend", bif.div_dividend, cur_a);
                chk("hold_divisor", bif.div_divisor, cur_b);
            end
            if (bif.div_in_valid && bif.div_enable) begin
                issues++;
                chk("issue_dz", expq.size() == 1 && !expq[0].dz, 1'b1);
            end
`ifdef DIV_ARB_TIMEOUT_EN
            if (bif.div_rst) begin
                drst_cnt++;
                chk("div_rst_time", cyc - last_gcyc, 2 + TMO);
            end
`else
            chk("div_rst_zero", bif.div_rst, 1'b0);
`endif
            if (bif.resp_valid) begin
                exp_t e;
                resp_cnt++;
                last_id  = int'(bif.resp_id);
                last_q   = bif.resp_quotient;
                last_err = bif.resp_err;
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got id %0d, none expected",
                             bif.resp_id);
                end else begin
                    e = expq.pop_front();
                    chk("resp_id", bif.resp_id, e.id);
                    chk("resp_quotient", bif.resp_quotient, e.q);
                    chk("resp_err", bif.resp_err, e.err);
                    if (!stalled) begin
                        if (e.dz)
                            chk("dz_latency", cyc - e.gcyc, 2);
                        else if (!e.err)
                            chk("resp_latency", cyc - ov_cyc, 2);
                    end
                end
            end
            if (bif.req_ready != '0) begin
                int   g, w;
                exp_t n;
                logic [D_W-1:0] a, b;
                g = -1;
                w = -1;
                for (int i = 0; i < N_REQ; i++)
                    if (bif.req_ready[i]) g = i;
                for (int i = 0; i < N_REQ; i++) begin
                    int k;
                    k = (ptr + i) % N_REQ;
                    if (w < 0 && bif.req_valid[k]) w = k;
                end
                chk("grant_index", g, w);
                chk("grant_idle", expq.size() == 0 && !busy, 1'b1);
                a = bif.req_dividend[g*D_W +: D_W];
                b = bif.req_divisor[g*D_W +: D_W];
                n.id   = g;
                n.dz   = (b == 0);
                n.err  = n.dz || hang;
                n.q    = n.err ? '1 : a / b;
                n.gcyc = cyc;
                expq.push_back(n);
                gnt_log.push_back(g);
                ptr       = (g + 1) % N_REQ;
                last_gcyc = cyc;
                stalled   = 1'b0;
                cur_a     = a;
                cur_b     = b;
                if (!n.dz) nz_grants++;
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(int id, logic [D_W-1:0] a, logic [D_W-1:0] b);
        bif.req_dividend[id*D_W +: D_W] = a;
        bif.req_divisor[id*D_W +: D_W]  = b;
    endtask

    // Raise mask; drop each bit once granted, or all at the end when hold=1.
    task automatic serve(logic [N_REQ-1:0] mask, int ngr, bit hold);
        int base, seen;
        base = gnt_log.size();
        seen = base;
        bif.req_valid = bif.req_valid | mask;
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #1;
            while (seen < gnt_log.size()) begin
                if (!hold) bif.req_valid[gnt_log[seen]] = 1'b0;
                seen++;
            end
            if (gnt_log.size() >= base + ngr) break;
        end
        if (hold) bif.req_valid = '0;
        chk("grant_count", gnt_log.size(), base + ngr);
    endtask

    task automatic wait_resps(int target, string name);
        for (int t = 0; t < 400 && resp_cnt < target; t++)
            @(posedge clk);
        #1;
        chk({name, "_resp_count"}, resp_cnt, target);
    endtask

    initial begin
        int rc, iss0;
        bif.req_valid    = '0;
        bif.req_dividend = '0;
        bif.req_divisor  = '0;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", bif.resp_valid, 1'b0);
        chk("rst_resp_id", bif.resp_id, '0);
        chk("rst_resp_quotient", bif.resp_quotient, '0);
        chk("rst_resp_err", bif.resp_err, 1'b0);
        chk("rst_div_in_valid", bif.div_in_valid, 1'b0);
        chk("rst_div_rst", bif.div_rst, 1'b0);
        chk("rst_div_dividend", bif.div_dividend, '0);
        chk("rst_div_divisor", bif.div_divisor, '0);
        chk("rst_busy", busy, 1'b0);
        tick(1);

        for (int i = 0; i < N_REQ; i++) set_op(i, 1000, 10);
        serve(4'b1111, 5, 1'b1);
        chk("rr_order0", gnt_log[0], 0);
        chk("rr_order1", gnt_log[1], 1);
        chk("rr_order2", gnt_log[2], 2);
        chk("rr_order3", gnt_log[3], 3);
        chk("rr_order4", gnt_log[4], 0);
        wait_resps(5, "rr");
        chk("rr_quotient", last_q, 100);

        set_op(0, 100, 7);
        serve(4'b0001, 1, 1'b0);
        wait_resps(6, "single");
        chk("single_id", last_id, 0);
        chk("single_q", last_q, 14);
        chk("single_err", last_err, 1'b0);

        iss0 = issues;
        set_op(2, 5, 0);
        serve(4'b0100, 1, 1'b0);
        wait_resps(7, "dz");
        chk("dz_id", last_id, 2);
        chk("dz_q", last_q, 32'hFFFF_FFFF);
        chk("dz_err", last_err, 1'b1);
        chk("dz_no_issue", issues, iss0);

        set_op(1, 3, 9);
        serve(4'b0010, 1, 1'b0);
        wait_resps(8, "small");
        chk("small_q", last_q, 0);
        chk("small_err", last_err, 1'b0);

        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        serve(4'b1000, 1, 1'b0);
        wait_resps(9, "equal");
        chk("equal_q", last_q, 1);

        set_op(1, 1000, 7);
        serve(4'b0010, 1, 1'b0);
        tick(2);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_enable", bif.div_enable, 1'b0);
            chk("stall_busy", busy, 1'b1);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        wait_resps(10, "stall");
        chk("stall_q", last_q, 142);
        chk("stall_id", last_id, 1);

        set_op(1, 50, 5);
        serve(4'b0010, 1, 1'b0);
        tick(3);
        chk("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rc = resp_cnt;
        tick(20);
        chk("rst_dropped_resp", resp_cnt, rc);
        chk("rst_idle", busy, 1'b0);
        set_op(1, 77, 7);
        set_op(3, 90, 9);
        serve(4'b1010, 2, 1'b0);
        chk("rst_first_grant", gnt_log[gnt_log.size()-2], 1);
        chk("rst_second_grant", gnt_log[gnt_log.size()-1], 3);
        wait_resps(rc + 2, "post_rst");
        chk("post_rst_q", last_q, 10);

`ifdef DIV_ARB_TIMEOUT_EN
        hang = 1'b1;
        rc = resp_cnt;
        set_op(0, 20, 4);
        serve(4'b0001, 1, 1'b0);
        wait_resps(rc + 1, "timeout");
        chk("timeout_q", last_q, 32'hFFFF_FFFF);
        chk("timeout_err", last_err, 1'b1);
        chk("timeout_pulses", drst_cnt, 1);
        hang = 1'b0;
`endif

        tick(5);
        chk("issue_total", issues, nz_grants);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
